// File: rtl/aes_resp_checker_if.sv
// Handshake bundle between the AES self-test sequencer/core output and the response checker.
// The master side pushes expected ciphertexts and presents core responses.
interface aes_resp_checker_if;
  logic         issue_valid;
  logic [127:0] issue_expected;
  logic         issue_ready;
  logic         rsp_done;
  logic [127:0] rsp_data;

  modport master (
    output issue_valid, issue_expected, rsp_done, rsp_data,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_expected, rsp_done, rsp_data,
    output issue_ready
  );
endinterface

// File: rtl/aes_resp_checker.sv
// In-order AES response checker: queues expected ciphertexts, compares each core output
// against the queue head, and keeps saturating pass/fail counts plus a first-mismatch capture.
module aes_resp_checker #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  aes_resp_checker_if.slave        bus,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         pass_count,
  output logic [CNT_W-1:0]         fail_count,
  output logic                     error,
  output logic                     orphan,
  output logic [CNT_W-1:0]         first_fail_idx,
  output logic [127:0]             first_fail_data,
  output logic [127:0]             first_fail_exp
);

  localparam int AW = $clog2(DEPTH);

  logic [127:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] resp_idx;
  logic             first_captured;
  logic             push;
  logic             pop;
  logic             empty;
  logic [127:0]     head;
  logic             match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign empty           = (pending == '0);
  assign bus.issue_ready = (pending != (AW+1)'(DEPTH));
  assign push            = bus.issue_valid & bus.issue_ready;
  assign pop             = bus.rsp_done & ~empty;
  assign head            = mem[rd_ptr];
  assign match           = (bus.rsp_data == head);

  // Storage needs no reset: only entries counted by pending are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= bus.issue_expected;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      pending         <= '0;
      resp_idx        <= '0;
      pass_count      <= '0;
      fail_count      <= '0;
      error           <= 1'b0;
      orphan          <= 1'b0;
      first_captured  <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      first_fail_exp  <= '0;
    end else if (clear) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      pending         <= '0;
      resp_idx        <= '0;
      pass_count      <= '0;
      fail_count      <= '0;
      error           <= 1'b0;
      orphan          <= 1'b0;
      first_captured  <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      first_fail_exp  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase

      // A same-cycle push is not yet at the head, so an empty-queue response is an orphan.
      if (bus.rsp_done && empty) begin
        orphan <= 1'b1;
        error  <= 1'b1;
      end

      if (pop) begin
        resp_idx <= sat_inc(resp_idx);
        if (match) begin
          pass_count <= sat_inc(pass_count);
        end else begin
          fail_count <= sat_inc(fail_count);
          error      <= 1'b1;
          if (!first_captured) begin
            first_captured  <= 1'b1;
            first_fail_idx  <= resp_idx;
            first_fail_data <= bus.rsp_data;
            first_fail_exp  <= head;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_resp_checker.sv
// Directed bench for aes_resp_checker: a vector table for match/mismatch/orphan/clear behaviour,
// plus hand-written sequences for full/wrap, clear, async reset and counter saturation.
module tb_aes_resp_checker;

  logic clk;
  logic reset;
  logic clear;
  logic clear2;

  aes_resp_checker_if bus ();
  aes_resp_checker_if bus2 ();

  logic [4:0]   pending;
  logic [31:0]  pass_count, fail_count, first_fail_idx;
  logic         error, orphan;
  logic [127:0] first_fail_data, first_fail_exp;

  logic [2:0]   pending2;
  logic [3:0]   pass_count2, fail_count2, first_fail_idx2;
  logic         error2, orphan2;
  logic [127:0] first_fail_data2, first_fail_exp2;

  aes_resp_checker #(.DEPTH(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus.slave),
    .pending(pending), .pass_count(pass_count), .fail_count(fail_count),
    .error(error), .orphan(orphan), .first_fail_idx(first_fail_idx),
    .first_fail_data(first_fail_data), .first_fail_exp(first_fail_exp)
  );

  aes_resp_checker #(.DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear2), .bus(bus2.slave),
    .pending(pending2), .pass_count(pass_count2), .fail_count(fail_count2),
    .error(error2), .orphan(orphan2), .first_fail_idx(first_fail_idx2),
    .first_fail_data(first_fail_data2), .first_fail_exp(first_fail_exp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         clr;
    logic         iv;
    logic [127:0] ie;
    logic         rd;
    logic [127:0] rdat;
    int           e_pend;
    int           e_pass;
    int           e_fail;
    logic         e_err;
    logic         e_orph;
    logic         chk_ff;
    int           e_idx;
    logic [127:0] e_fdata;
    logic [127:0] e_fexp;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic clr, logic iv, logic [127:0] ie, logic rd, logic [127:0] rdat,
                              int pnd, int ps, int fl, logic er, logic orp,
                              logic cf, int idx, logic [127:0] fd, logic [127:0] fe);
    vec_t r;
    r.clr = clr; r.iv = iv; r.ie = ie; r.rd = rd; r.rdat = rdat;
    r.e_pend = pnd; r.e_pass = ps; r.e_fail = fl; r.e_err = er; r.e_orph = orp;
    r.chk_ff = cf; r.e_idx = idx; r.e_fdata = fd; r.e_fexp = fe;
    return r;
  endfunction

  function automatic logic [127:0] v(int i);
    return {4{32'hA5C3_0000 ^ 32'(i)}};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(logic clr, logic iv, logic [127:0] ie, logic rd, logic [127:0] rdat);
    clear              = clr;
    bus.issue_valid    = iv;
    bus.issue_expected = ie;
    bus.rsp_done       = rd;
    bus.rsp_data       = rdat;
    @(posedge clk);
    #1;
    clear           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.rsp_done    = 1'b0;
  endtask

  task automatic cyc2(logic iv, logic [127:0] ie, logic rd, logic [127:0] rdat);
    bus2.issue_valid    = iv;
    bus2.issue_expected = ie;
    bus2.rsp_done       = rd;
    bus2.rsp_data       = rdat;
    @(posedge clk);
    #1;
    bus2.issue_valid = 1'b0;
    bus2.rsp_done    = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_pending"}, 128'(pending), 0);
    chk({tag, "_pass"}, 128'(pass_count), 0);
    chk({tag, "_fail"}, 128'(fail_count), 0);
    chk({tag, "_error"}, 128'(error), 0);
    chk({tag, "_orphan"}, 128'(orphan), 0);
    chk({tag, "_ff_idx"}, 128'(first_fail_idx), 0);
    chk({tag, "_ff_data"}, first_fail_data, 0);
    chk({tag, "_ff_exp"}, first_fail_exp, 0);
    chk({tag, "_ready"}, 128'(bus.issue_ready), 1);
  endtask

  logic [127:0] kk, a, b, c, x;

  initial begin
    reset = 1'b1; clear = 1'b0; clear2 = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_expected = '0; bus.rsp_done = 1'b0; bus.rsp_data = '0;
    bus2.issue_valid = 1'b0; bus2.issue_expected = '0; bus2.rsp_done = 1'b0; bus2.rsp_data = '0;

    kk = 128'h8ea2b7ca516745bfeafc49904b496089;
    a  = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    b  = 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe;
    c  = 128'h6969_8a8a_5a5a_a5a5_1357_9bdf_2468_ace0;
    x  = 128'h3243_f6a8_885a_308d_3131_98a2_e037_0734;

    tbl[0]  = mk(0, 1, kk, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,  0, 0,       1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  1, kk,      0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0,  0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, a,  0, 0,       1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, b,  0, 0,       2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, c,  1, a,       2, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,  1, b ^ 1,   1, 1, 1, 1, 0, 1, 1, b ^ 1, b);
    tbl[8]  = mk(0, 0, 0,  1, c ^ 2,   0, 1, 2, 1, 0, 1, 1, b ^ 1, b);
    tbl[9]  = mk(1, 0, 0,  0, 0,       0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, x,  1, 0,       1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0,  1, x,       0, 1, 0, 1, 1, 1, 0, 0, 0);

    #1;
    chk_all_zero("in_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("after_reset");

    // Table: FIPS-197 match, mismatch capture, orphan with same-cycle push, clears.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].clr, tbl[i].iv, tbl[i].ie, tbl[i].rd, tbl[i].rdat);
      chk($sformatf("v%0d_pending", i), 128'(pending), 128'(tbl[i].e_pend));
      chk($sformatf("v%0d_pass", i), 128'(pass_count), 128'(tbl[i].e_pass));
      chk($sformatf("v%0d_fail", i), 128'(fail_count), 128'(tbl[i].e_fail));
      chk($sformatf("v%0d_error", i), 128'(error), 128'(tbl[i].e_err));
      chk($sformatf("v%0d_orphan", i), 128'(orphan), 128'(tbl[i].e_orph));
      chk($sformatf("v%0d_ready", i), 128'(bus.issue_ready), 1);
      if (tbl[i].chk_ff) begin
        chk($sformatf("v%0d_ff_idx", i), 128'(first_fail_idx), 128'(tbl[i].e_idx));
        chk($sformatf("v%0d_ff_data", i), first_fail_data, tbl[i].e_fdata);
        chk($sformatf("v%0d_ff_exp", i), first_fail_exp, tbl[i].e_fexp);
      end
    end

    // Full, blocked push during pop, then sustained push/pop across pointer wrap.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, v(i), 0, 0);
    chk("full_pending", 128'(pending), 16);
    chk("full_ready", 128'(bus.issue_ready), 0);
    cyc(0, 1, v(999), 1, v(0));
    chk("full_pop_pending", 128'(pending), 15);
    chk("full_pop_ready", 128'(bus.issue_ready), 1);
    chk("full_pop_pass", 128'(pass_count), 1);
    for (int k = 0; k < 40; k++) cyc(0, 1, v(16 + k), 1, v(1 + k));
    chk("wrap_pass", 128'(pass_count), 41);
    chk("wrap_fail", 128'(fail_count), 0);
    chk("wrap_error", 128'(error), 0);
    chk("wrap_pending", 128'(pending), 15);
    for (int k = 0; k < 15; k++) cyc(0, 0, 0, 1, v(41 + k));
    chk("drain_pass", 128'(pass_count), 56);
    chk("drain_pending", 128'(pending), 0);

    // Synchronous clear wins over a same-cycle push and response.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, v(100 + i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, v(100 + i) ^ 1);
    chk("pre_clear_fail", 128'(fail_count), 3);
    chk("pre_clear_pending", 128'(pending), 5);
    cyc(1, 1, v(150), 1, v(103));
    chk_all_zero("clear_prio");

    // Asynchronous reset between edges, then responses are orphans.
    cyc(0, 1, v(200), 0, 0);
    cyc(0, 1, v(201), 1, v(200) ^ 4);
    chk("pre_reset_fail", 128'(fail_count), 1);
    chk("pre_reset_pending", 128'(pending), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc(0, 0, 0, 1, v(201));
    chk("post_reset_orphan", 128'(orphan), 1);
    chk("post_reset_error", 128'(error), 1);
    chk("post_reset_pass", 128'(pass_count), 0);
    chk("post_reset_fail", 128'(fail_count), 0);

    // Saturation on the 4-bit instance, including the saturated response index.
    for (int i = 0; i < 20; i++) begin
      cyc2(1, v(300 + i), 0, 0);
      cyc2(0, 0, 1, v(300 + i));
    end
    chk("sat_pass", 128'(pass_count2), 15);
    chk("sat_fail", 128'(fail_count2), 0);
    chk("sat_pending", 128'(pending2), 0);
    cyc2(1, v(400), 0, 0);
    cyc2(0, 0, 1, v(400) ^ 1);
    chk("sat_ff_fail", 128'(fail_count2), 1);
    chk("sat_ff_idx", 128'(first_fail_idx2), 15);
    chk("sat_ff_exp", first_fail_exp2, v(400));
    chk("sat_pass_hold", 128'(pass_count2), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
